// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle or iterative multiply, restoring divide,
// MTHI/MTLO writes, cancel/flush handling and a registered busy/done handshake.
module hilo_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int MUL_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div, neg_q, neg_r;
   logic [WIDTH-1:0] acc, quo, dsr;

   logic               is_mul_op, is_div_op, sgn_op, rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [2*WIDTH-1:0] rs_ext, rt_ext, prod_fast, mul_raw;
   logic [WIDTH:0]     div_trial, mul_sum;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   // Decode the requested op and form operand magnitudes and the single-cycle product
   always_comb begin
      is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
      is_div_op = (op == OP_DIV) || (op == OP_DIVU);
      sgn_op    = (op == OP_MULT) || (op == OP_DIV);
      rs_neg    = sgn_op & rs_val[WIDTH-1];
      rt_neg    = sgn_op & rt_val[WIDTH-1];
      rs_mag    = rs_neg ? -rs_val : rs_val;
      rt_mag    = rt_neg ? -rt_val : rt_val;
      rs_ext    = sgn_op ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
      rt_ext    = sgn_op ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
      prod_fast = rs_ext * rt_ext;
   end

   // Per-step divide trial, shift-add sum, and sign-corrected final results
   always_comb begin
      div_trial = {acc, quo[WIDTH-1]} - {1'b0, dsr};
      mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, dsr} : {(WIDTH+1){1'b0}});
      mul_raw   = {acc, quo};
      fix_hi    = {WIDTH{1'b0}};
      fix_lo    = {WIDTH{1'b0}};
      if (is_div) begin
         // A zero divisor leaves the dividend magnitude in acc, so re-signing it yields rs_val
         fix_hi = neg_r ? -acc : acc;
         if (dsr == {WIDTH{1'b0}}) begin
            fix_lo = {WIDTH{1'b1}};
         end else begin
            fix_lo = neg_q ? -quo : quo;
         end
      end else begin
         {fix_hi, fix_lo} = neg_q ? -mul_raw : mul_raw;
      end
   end

   // Control FSM, iteration datapath and architectural HI/LO registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= {CW{1'b0}};
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         acc      <= {WIDTH{1'b0}};
         quo      <= {WIDTH{1'b0}};
         dsr      <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid && !cancel) begin
                  if (op == OP_MTHI) begin
                     hi <= rs_val;
                  end else if (op == OP_MTLO) begin
                     lo <= rs_val;
                  end else if (is_mul_op && (MUL_MODE == 0)) begin
                     {hi, lo} <= prod_fast;
                     done     <= 1'b1;
                  end else if (is_mul_op || is_div_op) begin
                     state  <= is_div_op ? DIV : MUL;
                     busy   <= 1'b1;
                     cnt    <= {CW{1'b0}};
                     is_div <= is_div_op;
                     neg_q  <= rs_neg ^ rt_neg;
                     neg_r  <= rs_neg;
                     acc    <= {WIDTH{1'b0}};
                     quo    <= rs_mag;
                     dsr    <= rt_mag;
                     if (is_div_op && (rt_val != {WIDTH{1'b0}})) begin
                        div_zero <= 1'b0;
                     end
                  end
               end
            end
            MUL, DIV: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (state == DIV) begin
                     if (!div_trial[WIDTH]) begin
                        acc <= div_trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                     end else begin
                        acc <= {acc[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     acc <= mul_sum[WIDTH:1];
                     quo <= {mul_sum[0], quo[WIDTH-1:1]};
                  end
                  cnt <= cnt + CNT_ONE;
                  if (cnt == CNT_LAST) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!cancel) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  done <= 1'b1;
                  if (is_div && (dsr == {WIDTH{1'b0}})) begin
                     div_zero <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: drives both multiply modes in lockstep and compares against
// an arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          op_valid, cancel;
   logic [2:0]    op;
   logic [W-1:0]  rs_val, rt_val;
   logic          busy0, done0, dz0, busy1, done1, dz1;
   logic [W-1:0]  hi0, lo0, hi1, lo1;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [W-1:0]  m_hi, m_lo;
   logic          m_dz;

   hilo_muldiv_unit #(.WIDTH(W), .MUL_MODE(0)) u0 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .cancel(cancel), .busy(busy0), .done(done0), .div_zero(dz0), .hi(hi0), .lo(lo0));

   hilo_muldiv_unit #(.WIDTH(W), .MUL_MODE(1)) u1 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .cancel(cancel), .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural meaning of each op
   task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint      sa, sb, q, r, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: begin up = 64'(a) * 64'(b); m_hi = up[63:32]; m_lo = up[31:0]; end
         3'd3, 3'd4: begin
            if (b == 32'd0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
            end else if (o == 3'd3) begin
               q = sa / sb; r = sa % sb;
               m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
            end else begin
               m_lo = a / b; m_hi = a % b; m_dz = 1'b0;
            end
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic check_regs(input string tag);
      check_eq({tag, "_hi0"}, 64'(hi0), 64'(m_hi));
      check_eq({tag, "_lo0"}, 64'(lo0), 64'(m_lo));
      check_eq({tag, "_dz0"}, 64'(dz0), 64'(m_dz));
      check_eq({tag, "_hi1"}, 64'(hi1), 64'(m_hi));
      check_eq({tag, "_lo1"}, 64'(lo1), 64'(m_lo));
      check_eq({tag, "_dz1"}, 64'(dz1), 64'(m_dz));
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
      bit mulop, iter, fin0, fin1;
      int di0, di1, bc0, bc1, e_di0, e_di1, e_bc0, e_bc1;
      mulop = (o == 3'd1) || (o == 3'd2);
      iter  = mulop || (o == 3'd3) || (o == 3'd4);
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk);
      model_op(o, a, b);
      #1;
      op_valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
      di0 = -1; di1 = -1; bc0 = 0; bc1 = 0; fin0 = 1'b0; fin1 = 1'b0;
      for (int s = 0; s < 60; s++) begin
         if (s > 0) begin @(posedge clk); #1; end
         if (busy0) bc0++;
         if (busy1) bc1++;
         if (done0 && di0 < 0) di0 = s;
         if (done1 && di1 < 0) di1 = s;
         if (s == 0) begin
            check_eq({tag, "_done0_n1"}, 64'(done0), 64'(mulop));
            check_eq({tag, "_done1_n1"}, 64'(done1), 64'(1'b0));
         end
         if (hold && s == 3) begin op_valid = 1'b1; op = 3'd6; rs_val = $urandom; end
         if (hold && s == 20) op_valid = 1'b0;
         fin0 = iter ? (di0 >= 0) : 1'b1;
         fin1 = iter ? (di1 >= 0) : 1'b1;
         if (fin0 && fin1) break;
      end
      op_valid = 1'b0;
      check_eq({tag, "_finish"}, 64'({fin0, fin1}), 64'(2'b11));
      e_di0 = mulop ? 0 : (iter ? W + 1 : -1);
      e_di1 = iter ? W + 1 : -1;
      e_bc0 = (iter && !mulop) ? W + 1 : 0;
      e_bc1 = iter ? W + 1 : 0;
      check_eq({tag, "_dcyc0"}, 64'(di0), 64'(e_di0));
      check_eq({tag, "_dcyc1"}, 64'(di1), 64'(e_di1));
      check_eq({tag, "_busy0"}, 64'(bc0), 64'(e_bc0));
      check_eq({tag, "_busy1"}, 64'(bc1), 64'(e_bc1));
      check_regs(tag);
   endtask

   // Issue a DIV and flush it with cancel at edge N+k+1
   task automatic run_cancel(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int k);
      int nd;
      @(negedge clk);
      op_valid = 1'b1; op = 3'd3; rs_val = a; rt_val = b;
      @(posedge clk);
      if (b != 32'd0) m_dz = 1'b0;
      #1;
      op_valid = 1'b0;
      repeat (k) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      check_eq({tag, "_busy0"}, 64'(busy0), 64'(1'b0));
      check_eq({tag, "_busy1"}, 64'(busy1), 64'(1'b0));
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         nd += int'(done0) + int'(done1);
         @(posedge clk); #1;
      end
      check_eq({tag, "_nodone"}, 64'(nd), 64'(0));
      check_regs(tag);
   endtask

   initial begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      int sel;
      rst = 1'b0; op_valid = 1'b0; cancel = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      #22;
      check_eq("rst_busy", 64'({busy0, busy1}), 64'(2'b00));
      check_eq("rst_done", 64'({done0, done1}), 64'(2'b00));
      check_regs("rst");
      @(negedge clk) rst = 1'b1;

      run_op("mult",   3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
      run_op("divu",   3'd4, 32'd100,       32'd7,         1'b0);
      run_op("div_n",  3'd3, 32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op("div_ov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_z", 3'd4, 32'h0000_1234, 32'd0,         1'b0);
      run_op("div_z",  3'd3, 32'h8765_4321, 32'd0,         1'b0);
      run_op("multu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mult_m", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("hold",   3'd3, 32'h7FFF_0001, 32'hFFFF_FF03, 1'b1);
      run_op("mthi",   3'd5, 32'hAAAA_5555, 32'd0,         1'b0);
      run_cancel("cncl10", 32'h0001_0000, 32'd3, 10);
      run_op("mtlo",   3'd6, 32'h1357_9BDF, 32'd0,         1'b0);
      run_cancel("cnclfix", 32'h0000_0064, 32'd9, 32);

      // op_valid together with cancel while idle: dropped
      @(negedge clk);
      op_valid = 1'b1; op = 3'd5; rs_val = 32'h0BAD_F00D; cancel = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; cancel = 1'b0;
      check_regs("idlecncl");

      for (int n = 0; n < 40; n++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
         if (sel == 3) b = -$urandom_range(1, 15);
         run_op("rnd", o, a, b, ((o == 3'd3) || (o == 3'd4)) && (sel > 6));
      end

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      op_valid = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF; rt_val = 32'd17;
      @(posedge clk); #1 op_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      check_eq("arst_busy", 64'({busy0, busy1}), 64'(2'b00));
      check_eq("arst_done", 64'({done0, done1}), 64'(2'b00));
      check_regs("arst");
      @(negedge clk) rst = 1'b1;
      run_op("post_rst", 3'd3, 32'hFFFF_FF9C, 32'd7, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
